// File: rtl/generator.sv
// Free-running pattern source: PRBS16 LFSR with serial bit, square wave with rising-edge tick,
// sawtooth ramp and triangle wave. All state is registered; reset is synchronous and active-high.
module generator #(
  parameter int          WIDTH       = 8,
  parameter int          HALF_PERIOD = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             out,
  output logic [15:0]      lfsr,
  output logic             square,
  output logic             tick,
  output logic [WIDTH-1:0] ramp,
  output logic [WIDTH-1:0] tri_o
);

  localparam int              HC_W   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(HALF_PERIOD - 1);
  localparam logic [WIDTH-1:0] PEAK  = '1;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [15:0]      lfsr_q, lfsr_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic             square_q, square_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] ramp_q, ramp_d;
  logic [WIDTH-1:0] tri_q, tri_d;
  logic             down_q, down_d;
  logic             fb;

  always_comb begin
    fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d   = {lfsr_q[14:0], fb};
    hc_d     = hc_q + HC_W'(1);
    square_d = square_q;
    tick_d   = 1'b0;
    ramp_d   = ramp_q + ONE;
    tri_d    = tri_q;
    down_d   = down_q;

    // An all-zero state would lock the LFSR up forever; recover by reseeding.
    if (lfsr_q == 16'h0000) begin
      lfsr_d = LFSR_SEED;
    end

    if (hc_q == HC_MAX) begin
      hc_d     = '0;
      square_d = ~square_q;
      tick_d   = ~square_q;
    end

    // Direction flips on the edge that lands on the peak/trough, so each extreme lasts one cycle.
    if (!down_q) begin
      tri_d = tri_q + ONE;
      if (tri_q + ONE == PEAK) down_d = 1'b1;
    end else begin
      tri_d = tri_q - ONE;
      if (tri_q - ONE == '0) down_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q   <= LFSR_SEED;
      hc_q     <= '0;
      square_q <= 1'b0;
      tick_q   <= 1'b0;
      ramp_q   <= '0;
      tri_q    <= '0;
      down_q   <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      hc_q     <= hc_d;
      square_q <= square_d;
      tick_q   <= tick_d;
      ramp_q   <= ramp_d;
      tri_q    <= tri_d;
      down_q   <= down_d;
    end
  end

  assign out    = lfsr_q[15];
  assign lfsr   = lfsr_q;
  assign square = square_q;
  assign tick   = tick_q;
  assign ramp   = ramp_q;
  assign tri_o  = tri_q;

endmodule

// File: tb/tb_generator.sv
// Bench for generator: closed-form scoreboard model checked every edge, plus a table of
// hand-computed checkpoints, reset checks and a mid-run reset restart.
module tb_generator;

  localparam int W  = 8;
  localparam int HP = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         out;
  logic [15:0]  lfsr;
  logic         square;
  logic         tick;
  logic [W-1:0] ramp;
  logic [W-1:0] tri_v;

  generator #(.WIDTH(W), .HALF_PERIOD(HP), .LFSR_SEED(16'hACE1)) dut (
    .clk    (clk),
    .reset  (reset),
    .out    (out),
    .lfsr   (lfsr),
    .square (square),
    .tick   (tick),
    .ramp   (ramp),
    .tri_o  (tri_v)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]  lfsr;
    logic         out;
    logic         sq;
    logic         tk;
    logic [W-1:0] ramp;
    logic [W-1:0] tv;
  } obs_t;

  typedef struct {
    int           n;
    bit           chk_lfsr;
    logic [15:0]  lfsr;
    logic         sq;
    logic         tk;
    logic [W-1:0] ramp;
    logic [W-1:0] tv;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  obs_t sb_q[$];
  vec_t tbl[$];
  int   m_n;
  logic [15:0] m_lfsr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (n=%0d): got %h expected %h", name, m_n, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Expected outputs n edges after the reset edge, from closed-form descriptions of each wave.
  function automatic obs_t model(input int n, input logic [15:0] l);
    obs_t o;
    int   m;
    int   per;
    per    = 2 * ((1 << W) - 1);
    m      = n % per;
    o.lfsr = l;
    o.out  = l[15];
    o.sq   = ((n / HP) % 2) == 1;
    o.tk   = (n % (2 * HP)) == HP;
    o.ramp = W'(n % (1 << W));
    o.tv   = (m <= (1 << W) - 1) ? W'(m) : W'(per - m);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{lfsr: lfsr, out: out, sq: square, tk: tick, ramp: ramp, tv: tri_v};
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_lfsr"},   64'(lfsr),   64'(16'hACE1));
    check({tag, "_out"},    64'(out),    64'(1'b1));
    check({tag, "_square"}, 64'(square), 64'(1'b0));
    check({tag, "_tick"},   64'(tick),   64'(1'b0));
    check({tag, "_ramp"},   64'(ramp),   64'(0));
    check({tag, "_tri"},    64'(tri_v),  64'(0));
  endtask

  task automatic model_reset();
    m_n    = 0;
    m_lfsr = 16'hACE1;
    sb_q.delete();
  endtask

  task automatic run(input int nedges, input bit use_tbl);
    obs_t exp;
    obs_t act;
    for (int i = 0; i < nedges; i++) begin
      m_n++;
      m_lfsr = lfsr_step(m_lfsr);
      sb_q.push_back(model(m_n, m_lfsr));
      step();
      act = sample();
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(1), 64'(0));
      end else begin
        exp = sb_q.pop_front();
        check("sb_all", 64'(act), 64'(exp));
      end
      check("lfsr_nonzero", 64'(lfsr != 16'h0000), 64'(1));
      if (use_tbl) begin
        for (int k = 0; k < tbl.size(); k++) begin
          if (tbl[k].n == m_n) begin
            if (tbl[k].chk_lfsr) begin
              check("tbl_lfsr", 64'(lfsr), 64'(tbl[k].lfsr));
              check("tbl_out",  64'(out),  64'(tbl[k].lfsr[15]));
            end
            check("tbl_square", 64'(square), 64'(tbl[k].sq));
            check("tbl_tick",   64'(tick),   64'(tbl[k].tk));
            check("tbl_ramp",   64'(ramp),   64'(tbl[k].ramp));
            check("tbl_tri",    64'(tri_v),  64'(tbl[k].tv));
          end
        end
      end
    end
  endtask

  initial begin
    tbl.push_back('{n: 1,     chk_lfsr: 1, lfsr: 16'h59C3, sq: 0, tk: 0, ramp: 8'd1,   tv: 8'd1});
    tbl.push_back('{n: 4,     chk_lfsr: 0, lfsr: 16'h0,    sq: 1, tk: 1, ramp: 8'd4,   tv: 8'd4});
    tbl.push_back('{n: 5,     chk_lfsr: 0, lfsr: 16'h0,    sq: 1, tk: 0, ramp: 8'd5,   tv: 8'd5});
    tbl.push_back('{n: 8,     chk_lfsr: 0, lfsr: 16'h0,    sq: 0, tk: 0, ramp: 8'd8,   tv: 8'd8});
    tbl.push_back('{n: 12,    chk_lfsr: 0, lfsr: 16'h0,    sq: 1, tk: 1, ramp: 8'd12,  tv: 8'd12});
    tbl.push_back('{n: 255,   chk_lfsr: 0, lfsr: 16'h0,    sq: 1, tk: 0, ramp: 8'd255, tv: 8'd255});
    tbl.push_back('{n: 256,   chk_lfsr: 0, lfsr: 16'h0,    sq: 0, tk: 0, ramp: 8'd0,   tv: 8'd254});
    tbl.push_back('{n: 510,   chk_lfsr: 0, lfsr: 16'h0,    sq: 1, tk: 0, ramp: 8'd254, tv: 8'd0});
    tbl.push_back('{n: 511,   chk_lfsr: 0, lfsr: 16'h0,    sq: 1, tk: 0, ramp: 8'd255, tv: 8'd1});
    tbl.push_back('{n: 65535, chk_lfsr: 1, lfsr: 16'hACE1, sq: 1, tk: 0, ramp: 8'd255, tv: 8'd255});

    // Power-up reset for a single edge.
    model_reset();
    reset = 1'b1;
    step();
    check_reset_state("rst");
    reset = 1'b0;

    // Full LFSR period, with every wave checked on every edge.
    run(65535, 1'b1);

    // Continue, then reset mid-run and confirm the sequences restart identically.
    run(300, 1'b0);
    reset = 1'b1;
    step();
    check_reset_state("midrst");
    reset = 1'b0;
    model_reset();
    run(600, 1'b1);

    check("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
